// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS pipeline constants, opcodes and fetch FSM encoding
package mips_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [5:0] OP_R_FORMAT = 6'h00;
  localparam logic [5:0] OP_LW       = 6'h23;
  localparam logic [5:0] OP_SW       = 6'h2B;
  localparam logic [5:0] OP_BEQ      = 6'h04;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_DRAIN = 2'd1,
    ST_BUF   = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/ifid_pipe_reg.sv
// rtl/ifid_pipe_reg.sv - IF/ID pipeline register with hold, bubble insert and async reset
module ifid_pipe_reg
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_bubble,
  input  logic [DATA_W-1:0] i_instr,
  input  logic [ADDR_W-1:0] i_pc_plus4,
  output logic [DATA_W-1:0] o_instr,
  output logic [ADDR_W-1:0] o_pc_plus4,
  output logic              o_valid
);

  logic [DATA_W-1:0] r_instr;
  logic [ADDR_W-1:0] r_pc_plus4;
  logic              r_valid;

  // Bubble wins over load; neither asserted means hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr    <= DATA_W'(NOP_INSTR);
      r_pc_plus4 <= '0;
      r_valid    <= 1'b0;
    end else if (i_bubble) begin
      r_instr <= DATA_W'(NOP_INSTR);
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_instr    <= i_instr;
      r_pc_plus4 <= i_pc_plus4;
      r_valid    <= 1'b1;
    end
  end

  assign o_instr    = r_instr;
  assign o_pc_plus4 = r_pc_plus4;
  assign o_valid    = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC, imem handshake, one-entry buffer, IF/ID feed
module fetch_stage
  import mips_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter int              DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pc_hold,
  input  logic              ifid_hold,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0] ifid_pc_plus4,
  output logic              ifid_valid,
  output logic [ADDR_W-1:0] fetch_pc
);

  fetch_state_t      r_state, w_next_state;
  logic [ADDR_W-1:0] r_pc, w_next_pc;
  logic [ADDR_W-1:0] r_drain_addr, w_next_drain_addr;
  logic [DATA_W-1:0] r_buf_instr;
  logic [ADDR_W-1:0] r_buf_addr;
  logic              w_buf_load;
  logic              w_stall;
  logic              w_ifid_load;
  logic              w_ifid_bubble;
  logic [DATA_W-1:0] w_ifid_instr;
  logic [ADDR_W-1:0] w_ifid_pc_plus4;
  logic [ADDR_W-1:0] w_pc_plus4;
  logic [ADDR_W-1:0] w_buf_plus4;

  assign w_stall     = pc_hold | ifid_hold;
  assign w_pc_plus4  = r_pc + ADDR_W'(4);
  assign w_buf_plus4 = r_buf_addr + ADDR_W'(4);

  assign imem_req  = (r_state != ST_BUF);
  assign imem_addr = (r_state == ST_DRAIN) ? r_drain_addr : r_pc;
  assign fetch_pc  = r_pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_FETCH;
      r_pc         <= RESET_PC;
      r_drain_addr <= RESET_PC;
      r_buf_instr  <= '0;
      r_buf_addr   <= '0;
    end else begin
      r_state      <= w_next_state;
      r_pc         <= w_next_pc;
      r_drain_addr <= w_next_drain_addr;
      if (w_buf_load) begin
        r_buf_instr <= imem_rdata;
        r_buf_addr  <= r_pc;
      end
    end
  end

  always_comb begin
    w_next_state      = r_state;
    w_next_pc         = r_pc;
    w_next_drain_addr = r_drain_addr;
    w_buf_load        = 1'b0;
    w_ifid_load       = 1'b0;
    w_ifid_bubble     = 1'b0;
    w_ifid_instr      = imem_rdata;
    w_ifid_pc_plus4   = w_pc_plus4;

    // A stalled beq is re-presented once its operands are ready, so it is ignored here.
    if (branch_taken && !w_stall) begin
      w_next_pc     = branch_target;
      w_ifid_bubble = 1'b1;
      if (r_state == ST_FETCH && !imem_ready) begin
        w_next_drain_addr = r_pc;
        w_next_state      = ST_DRAIN;
      end else if (r_state == ST_DRAIN && !imem_ready) begin
        w_next_state = ST_DRAIN;
      end else begin
        w_next_state = ST_FETCH;
      end
    end else begin
      unique case (r_state)
        ST_FETCH: begin
          if (imem_ready) begin
            if (w_stall) begin
              w_buf_load   = 1'b1;
              w_next_state = ST_BUF;
            end else begin
              w_ifid_load = 1'b1;
              w_next_pc   = w_pc_plus4;
            end
          end else if (!w_stall) begin
            w_ifid_bubble = 1'b1;
          end
        end
        ST_DRAIN: begin
          if (imem_ready) w_next_state = ST_FETCH;
          if (!w_stall)   w_ifid_bubble = 1'b1;
        end
        ST_BUF: begin
          if (!w_stall) begin
            w_ifid_load     = 1'b1;
            w_ifid_instr    = r_buf_instr;
            w_ifid_pc_plus4 = w_buf_plus4;
            w_next_pc       = w_buf_plus4;
            w_next_state    = ST_FETCH;
          end
        end
        default: w_next_state = ST_FETCH;
      endcase
    end
  end

  ifid_pipe_reg #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ifid (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_ifid_load),
    .i_bubble   (w_ifid_bubble),
    .i_instr    (w_ifid_instr),
    .i_pc_plus4 (w_ifid_pc_plus4),
    .o_instr    (ifid_instr),
    .o_pc_plus4 (ifid_pc_plus4),
    .o_valid    (ifid_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        pc_hold;
  logic        ifid_hold;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;
  logic [31:0] fetch_pc;

  int n_tests;
  int n_fail;
  int n_wait;
  int wait_cnt;

  fetch_stage #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pc_hold       (pc_hold),
    .ifid_hold     (ifid_hold),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .ifid_instr    (ifid_instr),
    .ifid_pc_plus4 (ifid_pc_plus4),
    .ifid_valid    (ifid_valid),
    .fetch_pc      (fetch_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: n_wait idle cycles per request, then one response; words tagged by address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       wait_cnt <= 0;
    else if (imem_req && !imem_ready) wait_cnt <= wait_cnt + 1;
    else                             wait_cnt <= 0;
  end

  assign imem_ready = imem_req && (wait_cnt == n_wait);
  assign imem_rdata = {8'hEE, imem_addr[23:0]};

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {8'hEE, a[23:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    n_wait = 0;
    reset = 1'b1;
    pc_hold = 1'b0;
    ifid_hold = 1'b0;
    branch_taken = 1'b0;
    branch_target = '0;
    #12;
    check("rst_valid", 32'(ifid_valid), 32'd0);
    check("rst_instr", ifid_instr, 32'h0);
    check("rst_pp4", ifid_pc_plus4, 32'h0);
    check("rst_pc", fetch_pc, 32'h0);
    reset = 1'b0;
    #1;

    // 1: streaming at one instruction per cycle
    check("t1_addr0", imem_addr, 32'h0);
    tick();
    check("t1_addr4", imem_addr, 32'h4);
    check("t1_pp4_4", ifid_pc_plus4, 32'h4);
    check("t1_valid", 32'(ifid_valid), 32'd1);
    check("t1_instr0", ifid_instr, word_at(32'h0));
    tick();
    check("t1_addr8", imem_addr, 32'h8);
    check("t1_pp4_8", ifid_pc_plus4, 32'h8);

    // 2: stall while the response for 8 arrives
    pc_hold = 1'b1;
    tick();
    check("t2_req_buf", 32'(imem_req), 32'd0);
    check("t2_hold_pp4", ifid_pc_plus4, 32'h8);
    check("t2_hold_instr", ifid_instr, word_at(32'h4));
    check("t2_hold_pc", fetch_pc, 32'h8);
    pc_hold = 1'b0;
    ifid_hold = 1'b1;
    tick();
    check("t2_req_buf2", 32'(imem_req), 32'd0);
    check("t2_hold_pp4_2", ifid_pc_plus4, 32'h8);
    ifid_hold = 1'b0;
    tick();
    check("t2_rel_instr", ifid_instr, word_at(32'h8));
    check("t2_rel_pp4", ifid_pc_plus4, 32'hC);
    check("t2_rel_addr", imem_addr, 32'hC);
    tick();
    check("t2_next_pp4", ifid_pc_plus4, 32'h10);
    check("t2_next_instr", ifid_instr, word_at(32'hC));

    // 3: redirect to 0x40
    branch_taken = 1'b1;
    branch_target = 32'h40;
    tick();
    branch_taken = 1'b0;
    check("t3_bub_valid", 32'(ifid_valid), 32'd0);
    check("t3_bub_instr", ifid_instr, 32'h0);
    check("t3_addr", imem_addr, 32'h40);
    tick();
    check("t3_instr", ifid_instr, word_at(32'h40));
    check("t3_pp4", ifid_pc_plus4, 32'h44);
    check("t3_valid", 32'(ifid_valid), 32'd1);

    // 5: branch under stall is ignored
    pc_hold = 1'b1;
    ifid_hold = 1'b1;
    branch_taken = 1'b1;
    branch_target = 32'h100;
    tick();
    check("t5_pc", fetch_pc, 32'h44);
    check("t5_pp4", ifid_pc_plus4, 32'h44);
    check("t5_instr", ifid_instr, word_at(32'h40));
    pc_hold = 1'b0;
    ifid_hold = 1'b0;
    branch_taken = 1'b0;
    tick();
    check("t5_rel_pp4", ifid_pc_plus4, 32'h48);
    check("t5_rel_pc", fetch_pc, 32'h48);

    // 4: redirect while a slow request at 0x8 is outstanding
    branch_taken = 1'b1;
    branch_target = 32'h8;
    tick();
    branch_taken = 1'b0;
    n_wait = 3;
    tick();
    check("t4_addr8", imem_addr, 32'h8);
    check("t4_bub", 32'(ifid_valid), 32'd0);
    branch_taken = 1'b1;
    branch_target = 32'h40;
    tick();
    branch_taken = 1'b0;
    check("t4_drain_addr", imem_addr, 32'h8);
    check("t4_drain_pc", fetch_pc, 32'h40);
    tick();
    check("t4_drain_addr2", imem_addr, 32'h8);
    check("t4_drain_req", 32'(imem_req), 32'd1);
    tick();
    check("t4_new_addr", imem_addr, 32'h40);
    check("t4_new_valid", 32'(ifid_valid), 32'd0);
    check("t4_new_instr", ifid_instr, 32'h0);
    n_wait = 0;
    tick();
    check("t4_instr40", ifid_instr, word_at(32'h40));
    check("t4_pp4", ifid_pc_plus4, 32'h44);

    // 6: asynchronous reset in the middle of a drain
    n_wait = 3;
    branch_taken = 1'b1;
    branch_target = 32'h80;
    tick();
    branch_taken = 1'b0;
    check("t6_pre_pc", fetch_pc, 32'h80);
    check("t6_pre_addr", imem_addr, 32'h44);
    reset = 1'b1;
    #2;
    check("t6_valid", 32'(ifid_valid), 32'd0);
    check("t6_instr", ifid_instr, 32'h0);
    check("t6_pc", fetch_pc, 32'h0);
    check("t6_addr", imem_addr, 32'h0);
    n_wait = 0;
    #2;
    reset = 1'b0;
    tick();
    check("t6_resume_pp4", ifid_pc_plus4, 32'h4);
    check("t6_resume_instr", ifid_instr, word_at(32'h0));

    // PC+4 wraps at the top of the address space
    branch_taken = 1'b1;
    branch_target = 32'hFFFF_FFFC;
    tick();
    branch_taken = 1'b0;
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    check("wrap_pp4", ifid_pc_plus4, 32'h0);
    check("wrap_pc", fetch_pc, 32'h0);
    check("wrap_instr", ifid_instr, word_at(32'hFFFF_FFFC));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
